// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a single register-file write port shared by ALU and LSU,
// with a busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_wr,
  output logic              iss_stall,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              wb_err
);

  localparam int NREG = 1 << ADDR_W;

  // High when the LSU should win the next simultaneous request (ALU won last).
  logic              lsu_pri_reg;
  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic              we_reg;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] wd_reg;
  logic              err_reg;

  logic              accept;
  logic [ADDR_W-1:0] acc_rd;
  logic [DATA_W-1:0] acc_data;
  logic              issue_set;
  logic              wb_clr;

  assign alu_ready = rst & alu_valid & (~lsu_valid | ~lsu_pri_reg);
  assign lsu_ready = rst & lsu_valid & (~alu_valid | lsu_pri_reg);
  assign accept    = alu_ready | lsu_ready;
  assign acc_rd    = lsu_ready ? lsu_rd   : alu_rd;
  assign acc_data  = lsu_ready ? lsu_data : alu_data;

  // The stall looks only at registered busy bits, so a same-edge clear does not bypass.
  assign iss_stall = rst & iss_valid &
                     (busy_reg[iss_rs1] | busy_reg[iss_rs2] | (iss_wr & busy_reg[iss_rd]));
  assign issue_set = iss_valid & iss_wr & ~iss_stall & (iss_rd != '0);
  assign wb_clr    = accept & (acc_rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        // Set is ORed after the clear so an issue wins over a write-back on the same edge.
        assign busy_next[gi] = (issue_set & (iss_rd == ADDR_W'(gi))) |
                               (busy_reg[gi] & ~(wb_clr & (acc_rd == ADDR_W'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_pri_reg <= 1'b0;
      busy_reg    <= '0;
      we_reg      <= 1'b0;
      a_reg       <= '0;
      wd_reg      <= '0;
      err_reg     <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      we_reg   <= wb_clr;
      if (accept) begin
        lsu_pri_reg <= alu_ready;
        a_reg       <= acc_rd;
        wd_reg      <= acc_data;
      end
      if (wb_clr && !busy_reg[acc_rd]) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign WE3    = we_reg;
  assign A3     = a_reg;
  assign WD3    = wd_reg;
  assign wb_err = err_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: expected writes are queued when stimulus is
// driven and a negedge monitor checks every WE3 slot against that queue.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, iss_valid, iss_wr;
  logic [4:0]  alu_rd, lsu_rd, iss_rs1, iss_rs2, iss_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, iss_stall, WE3, wb_err;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_wr(iss_wr), .iss_stall(iss_stall),
    .WE3(WE3), .A3(A3), .WD3(WD3), .wb_err(wb_err)
  );

  // Scoreboard monitor: each registered write slot must match the queue head for this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (WE3) begin
        tests_run++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          tests_failed++;
          $display("FAIL wb_unexpected: got write A3=%0d WD3=%h at cyc %0d, expected no write", A3, WD3, cyc);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          if (A3 !== e.rd || WD3 !== e.data) begin
            tests_failed++;
            $display("FAIL wb_data: got A3=%0d WD3=%h, expected A3=%0d WD3=%h", A3, WD3, e.rd, e.data);
          end else begin
            $display("[TB] cyc %0d write A3=%0d WD3=%h ok", cyc, A3, WD3);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        wb_t e;
        e = exp_q.pop_front();
        tests_run++;
        tests_failed++;
        $display("FAIL wb_missing: got WE3=0 at cyc %0d, expected write A3=%0d WD3=%h", cyc, e.rd, e.data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_wr = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.cyc = cyc + 1;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd3; iss_rs1 = 5'd3; iss_rs2 = 5'd4;
    tick(); #1;
    tests_run++; if (alu_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
    tests_run++; if (lsu_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_lsu_ready: got %b want 0", lsu_ready); end
    tests_run++; if (iss_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_iss_stall: got %b want 0", iss_stall); end
    tests_run++; if (WE3 !== 1'b0) begin tests_failed++; $display("FAIL reset_we3: got %b want 0", WE3); end
    tests_run++; if (A3 !== 5'd0) begin tests_failed++; $display("FAIL reset_a3: got %0d want 0", A3); end
    tests_run++; if (WD3 !== 32'd0) begin tests_failed++; $display("FAIL reset_wd3: got %h want 0", WD3); end
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_err: got %b want 0", wb_err); end
    tick(); #1;
    tests_run++; if (WE3 !== 1'b0) begin tests_failed++; $display("FAIL reset_no_accept: got WE3=%b want 0", WE3); end
    $display("[TB] reset: outputs held low with requests presented");
    idle();
    rst = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_hazard();
    idle(); iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd5; #1;
    tests_run++; if (iss_stall !== 1'b0) begin tests_failed++; $display("FAIL hazard_issue_free: got %b want 0", iss_stall); end
    tick();
    iss_wr = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h20; #1;
    tests_run++; if (iss_stall !== 1'b1) begin tests_failed++; $display("FAIL hazard_stall: got %b want 1", iss_stall); end
    tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL hazard_alu_ready: got %b want 1", alu_ready); end
    tests_run++; if (lsu_ready !== 1'b0) begin tests_failed++; $display("FAIL hazard_lsu_ready: got %b want 0", lsu_ready); end
    push_exp(5'd5, 32'h20);
    tick();
    alu_valid = 1'b0; #1;
    tests_run++; if (iss_stall !== 1'b0) begin tests_failed++; $display("FAIL hazard_release: got %b want 0", iss_stall); end
    tests_run++; if (WE3 !== 1'b1) begin tests_failed++; $display("FAIL hazard_we3: got %b want 1", WE3); end
    $display("[TB] hazard: rd=5 stall and release");
    tick(); idle();
  endtask

  task automatic test_rd_zero();
    idle(); iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd8; #1;
    tests_run++; if (iss_stall !== 1'b0) begin tests_failed++; $display("FAIL rdzero_issue8: got %b want 0", iss_stall); end
    tick(); idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hA0; #1;
    tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL rdzero_alu_ready: got %b want 1", alu_ready); end
    tick(); idle();
    iss_valid = 1'b1; iss_rs1 = 5'd8; #1;
    tests_run++; if (iss_stall !== 1'b1) begin tests_failed++; $display("FAIL rdzero_busy_kept: got %b want 1", iss_stall); end
    tests_run++; if (WE3 !== 1'b0) begin tests_failed++; $display("FAIL rdzero_no_write: got %b want 0", WE3); end
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL rdzero_wb_err: got %b want 0", wb_err); end
    iss_rs1 = 5'd0; iss_wr = 1'b1; iss_rd = 5'd0; #1;
    tests_run++; if (iss_stall !== 1'b0) begin tests_failed++; $display("FAIL rdzero_r0_free: got %b want 0", iss_stall); end
    tick(); idle();
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88; #1;
    tests_run++; if (lsu_ready !== 1'b1) begin tests_failed++; $display("FAIL rdzero_lsu_ready: got %b want 1", lsu_ready); end
    push_exp(5'd8, 32'h88);
    tick(); idle(); #1;
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL rdzero_err_after: got %b want 0", wb_err); end
    $display("[TB] rd_zero: write to r0 consumed silently");
  endtask

  task automatic test_round_robin();
    idle(); rst = 1'b0;
    tick(); rst = 1'b1;
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd6;
    tick(); iss_rd = 5'd7;
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      logic exp_alu;
      exp_alu = ((i % 2) == 0);
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hA600 + 32'(i);
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hB700 + 32'(i);
      #1;
      tests_run++; if (alu_ready !== exp_alu) begin tests_failed++; $display("FAIL rr_alu_ready[%0d]: got %b want %b", i, alu_ready, exp_alu); end
      tests_run++; if (lsu_ready !== !exp_alu) begin tests_failed++; $display("FAIL rr_lsu_ready[%0d]: got %b want %b", i, lsu_ready, !exp_alu); end
      if (exp_alu) push_exp(5'd6, 32'hA600 + 32'(i));
      else         push_exp(5'd7, 32'hB700 + 32'(i));
      if (i == 2) begin
        tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL rr_err_early: got %b want 0", wb_err); end
      end
      $display("[TB] rr grant %0d: alu_ready=%b lsu_ready=%b", i, alu_ready, lsu_ready);
      tick();
    end
    idle();
    tick(); #1;
    tests_run++; if (wb_err !== 1'b1) begin tests_failed++; $display("FAIL rr_err_on_rewrite: got %b want 1", wb_err); end
  endtask

  task automatic test_set_wins();
    idle();
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd6;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'hC6; #1;
    tests_run++; if (iss_stall !== 1'b0) begin tests_failed++; $display("FAIL setwins_issue: got %b want 0", iss_stall); end
    tests_run++; if (lsu_ready !== 1'b1) begin tests_failed++; $display("FAIL setwins_lsu_ready: got %b want 1", lsu_ready); end
    push_exp(5'd6, 32'hC6);
    tick(); idle();
    iss_valid = 1'b1; iss_rs2 = 5'd6; #1;
    tests_run++; if (iss_stall !== 1'b1) begin tests_failed++; $display("FAIL setwins_busy6: got %b want 1", iss_stall); end
    tick(); idle();
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hD6; #1;
    tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL setwins_alu_ready: got %b want 1", alu_ready); end
    push_exp(5'd6, 32'hD6);
    tick(); idle();
    iss_valid = 1'b1; iss_rs2 = 5'd6; #1;
    tests_run++; if (iss_stall !== 1'b0) begin tests_failed++; $display("FAIL setwins_cleared: got %b want 0", iss_stall); end
    $display("[TB] set_wins: busy[6] survives same-edge write-back");
    tick(); idle();
  endtask

  task automatic test_wb_err();
    idle(); rst = 1'b0; #1;
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL err_async_clear: got %b want 0", wb_err); end
    tick(); rst = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99; #1;
    tests_run++; if (lsu_ready !== 1'b1) begin tests_failed++; $display("FAIL err_lsu_ready: got %b want 1", lsu_ready); end
    push_exp(5'd9, 32'h99);
    for (int k = 0; k < 3; k++) begin
      tick(); idle(); #1;
      tests_run++; if (wb_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky[%0d]: got %b want 1", k, wb_err); end
    end
    rst = 1'b0; #1;
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL err_reset_clear: got %b want 0", wb_err); end
    $display("[TB] wb_err: set on rd=9 not busy, cleared by reset");
    tick(); rst = 1'b1;
  endtask

  task automatic test_reset_midflight();
    idle(); iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd10;
    tick(); idle();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1234; #1;
    tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_alu_ready: got %b want 1", alu_ready); end
    #2 rst = 1'b0; #1;
    tests_run++; if (alu_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready_in_reset: got %b want 0", alu_ready); end
    tick(); #1;
    tests_run++; if (WE3 !== 1'b0) begin tests_failed++; $display("FAIL mid_we3_reset: got %b want 0", WE3); end
    rst = 1'b1; idle();
    iss_valid = 1'b1; iss_rs1 = 5'd10; #1;
    tests_run++; if (iss_stall !== 1'b0) begin tests_failed++; $display("FAIL mid_busy_cleared: got %b want 0", iss_stall); end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      tests_run++; if (WE3 !== 1'b0) begin tests_failed++; $display("FAIL mid_no_write[%0d]: got %b want 0", k, WE3); end
    end
    $display("[TB] reset_midflight: pending write discarded");
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    test_reset();
    test_hazard();
    test_rd_zero();
    test_round_robin();
    test_set_wins();
    test_wb_err();
    test_reset_midflight();
    tick(); tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drained: got %0d pending writes, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
